spi_ram_ctrl: RTL
=================

Name: spi_ram_ctrl

Overview:
- Parametrised command-decoded single-port RAM behind the SPI slave.
- The slave delivers one (DATA_W+2)-bit word per rx_valid pulse. The top 2 bits are the opcode and the low DATA_W bits are the payload.
- Adds over the previous RAM generation: configurable data and address width, optional address auto-increment for bursts, a tx_valid/tx_ready handshake toward the SPI shifter, and a sticky overflow flag for reads issued while a previous read is still unconsumed.

Parameters:
- DATA_W, 8, memory word width and payload width; must be >= ADDR_W.
- ADDR_W, 8, address width; memory depth is 2**ADDR_W words.
- AUTO_INC, 1, 1 = write/read address increments after each data write/read; 0 = addresses hold.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- din  input  DATA_W+2  command word: din[DATA_W+1:DATA_W] = opcode, din[DATA_W-1:0] = payload.
- rx_valid  input  1  din qualifier; one command consumed per cycle with rx_valid=1.
- tx_ready  input  1  SPI shifter accepts dout this cycle when tx_valid=1.
- err_clr  input  1  clears err_ovf.
- dout  output  DATA_W  read data.
- tx_valid  output  1  dout valid, held until accepted.
- err_ovf  output  1  sticky: read command dropped because tx slot was occupied.
- wr_addr_o  output  ADDR_W  current write address (debug/coverage).
- rd_addr_o  output  ADDR_W  current read address (debug/coverage).

Behaviour:
- Reset (rst_n=0 at posedge): dout=0, tx_valid=0, err_ovf=0, wr_addr=0, rd_addr=0. Memory contents are not reset. Reset overrides all other inputs, including a pending read.
- Opcodes, acted on only when rx_valid=1:
  - 00 SET_WR: wr_addr <= din[ADDR_W-1:0]; upper payload bits ignored.
  - 01 WRITE: mem[wr_addr] <= din[DATA_W-1:0]; if AUTO_INC, wr_addr <= wr_addr+1.
  - 10 SET_RD: rd_addr <= din[ADDR_W-1:0].
  - 11 READ: if the tx slot is free, dout <= mem[rd_addr], tx_valid <= 1, and if AUTO_INC, rd_addr <= rd_addr+1.
- Tx slot free means tx_valid=0, or tx_valid=1 and tx_ready=1 in the same cycle.
- Read latency: dout/tx_valid update on the posedge that samples the READ (1 cycle).
- Dropped READ: if the slot is occupied (tx_valid=1, tx_ready=0):
  - command dropped; rd_addr, dout and tx_valid unchanged;
  - err_ovf <= 1.
- Handshake: when tx_valid=1 and tx_ready=1 and no accepted READ in the same cycle, tx_valid <= 0 next cycle; dout holds its last value.
- READ in the accept cycle: a READ accepted in the same cycle as tx_ready loads new data, and tx_valid stays 1 (back-to-back).
- tx_ready with tx_valid=0: no effect.
- err_ovf: set by a dropped READ; cleared by err_clr=1. If set and clear occur in the same cycle, set wins.
- Address wrap: increments are modulo 2**ADDR_W; address 2**ADDR_W-1 wraps to 0 with no flag.
- SET_WR and WRITE never affect tx_valid, dout or rd_addr. SET_RD never affects dout or tx_valid.
- Only one command is possible per cycle, so there are no read/write collisions on the memory.
- rx_valid=0: all state holds except the handshake clear of tx_valid and err_clr.

Test Plan:
- Reset, then SET_WR 0x10, WRITE 0xA5, SET_RD 0x10, READ with tx_ready=1 the following cycle -> dout=0xA5, tx_valid=1 for exactly one cycle, err_ovf=0.
- AUTO_INC=1: SET_WR 0xFE, WRITE 0x11, 0x22, 0x33 -> mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33, wr_addr_o=0x01. Then SET_RD 0xFE and 3 READs, each acked -> dout sequence 0x11, 0x22, 0x33; rd_addr_o=0x01.
- tx_ready=0 held, two READs in a row -> first loads dout and sets tx_valid. Second is dropped: err_ovf=1, rd_addr_o advanced only once, dout unchanged. Then err_clr=1 -> err_ovf=0.
- READ issued in the same cycle as tx_ready=1 on a pending tx -> new data on dout next cycle, tx_valid stays 1 with no gap, err_ovf=0.
- AUTO_INC=0, DATA_W=16, ADDR_W=6: SET_WR 0xFFC5 (addr 0x05), WRITE 0xBEEF twice, SET_RD 0x05, READ -> dout=0xBEEF; wr_addr_o and rd_addr_o stay 0x05.
- rst_n=0 asserted while tx_valid=1 and err_ovf=1 -> next cycle dout=0, tx_valid=0, err_ovf=0, addresses 0; a READ presented during reset is ignored.

Source files
------------

// File: rtl/spi_ram_ctrl.sv
// Command-decoded single-port RAM sitting behind the SPI slave.
// Decodes opcode/payload words and serves reads through a one-deep tx slot.
module spi_ram_ctrl #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned AUTO_INC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    input  logic              tx_ready,
    input  logic              err_clr,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              err_ovf,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [ADDR_W-1:0] rd_addr_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        OP_SET_WR = 2'b00,
        OP_WRITE  = 2'b01,
        OP_SET_RD = 2'b10,
        OP_READ   = 2'b11
    } opcode_e;

    logic [DATA_W-1:0] mem [DEPTH];

    opcode_e           op_c;
    logic [DATA_W-1:0] payload_c;
    logic [ADDR_W-1:0] addr_arg_c;
    logic              slot_free_c;
    logic              set_wr_c;
    logic              write_c;
    logic              set_rd_c;
    logic              rd_accept_c;
    logic              rd_drop_c;

    // Command decode; a read only fits when the slot is empty or draining now
    always_comb begin
        op_c        = opcode_e'(din[DATA_W+1:DATA_W]);
        payload_c   = din[DATA_W-1:0];
        addr_arg_c  = din[ADDR_W-1:0];
        slot_free_c = !tx_valid || tx_ready;
        set_wr_c    = rx_valid && (op_c == OP_SET_WR);
        write_c     = rx_valid && (op_c == OP_WRITE);
        set_rd_c    = rx_valid && (op_c == OP_SET_RD);
        rd_accept_c = rx_valid && (op_c == OP_READ) && slot_free_c;
        rd_drop_c   = rx_valid && (op_c == OP_READ) && !slot_free_c;
    end

    // Storage is not reset, but writes are blocked while reset is held
    always_ff @(posedge clk) begin
        if (rst_n && write_c) begin
            mem[wr_addr_o] <= payload_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout      <= '0;
            tx_valid  <= 1'b0;
            err_ovf   <= 1'b0;
            wr_addr_o <= '0;
            rd_addr_o <= '0;
        end else begin
            if (set_wr_c) begin
                wr_addr_o <= addr_arg_c;
            end else if (write_c && (AUTO_INC != 0)) begin
                wr_addr_o <= wr_addr_o + ADDR_W'(1);
            end

            if (set_rd_c) begin
                rd_addr_o <= addr_arg_c;
            end else if (rd_accept_c && (AUTO_INC != 0)) begin
                rd_addr_o <= rd_addr_o + ADDR_W'(1);
            end

            if (rd_accept_c) begin
                dout     <= mem[rd_addr_o];
                tx_valid <= 1'b1;
            end else if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
            end

            // A drop in the same cycle as a clear keeps the flag set
            if (rd_drop_c) begin
                err_ovf <= 1'b1;
            end else if (err_clr) begin
                err_ovf <= 1'b0;
            end
        end
    end

endmodule
